tdm_clkgen: RTL and testbench

- Parametrised I2S/TDM master clock generator. Successor to the fixed 2-channel I2S clock generator.
- Derives the bit clock (sclk) and frame clock (lrclk) from the master clock clk.
- Supports N slots of configurable width and four frame-sync formats selectable at runtime.
- Emits clk-domain strobes plus slot/bit indices so serializers and deserializers stay fully synchronous to clk.

---
 rtl/tdm_clkgen_pkg.sv | 23 ++
 rtl/tdm_clkgen_if.sv | 51 +++++
 rtl/tdm_clkgen_clk_div.sv | 58 +++++
 rtl/tdm_clkgen.sv | 135 +++++++++++++
 tb/tb_tdm_clkgen.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_clkgen_pkg.sv
// i2s_pkg: shared types and helpers for the I2S/TDM clock generator and the
// serializer/deserializer blocks that consume its strobes.
//   i2s_fmt_t  - frame-sync format selector
//   frame_bits - data bits per frame (slots * slot width)
//   idx_w      - index width for a count, never below 1 bit
package i2s_pkg;

  typedef enum logic [1:0] {
    FMT_I2S   = 2'd0,
    FMT_LJ    = 2'd1,
    FMT_DSP_A = 2'd2,
    FMT_DSP_B = 2'd3
  } i2s_fmt_t;

  function automatic int frame_bits(input int num_slots, input int slot_w);
    return num_slots * slot_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_clkgen_if.sv
// tdm_clkgen_if: control inputs and timing outputs of the TDM clock generator.
//   master modport - the clock generator (consumes en/fmt, drives timing)
//   slave  modport - a controller/consumer (drives en/fmt, observes timing)
// Signals: en, fmt, sclk, lrclk, bclk_rise, bclk_fall, frame_start, slot,
// bit_idx, and frame_cnt when TDM_CLKGEN_FRAME_CTR_EN is defined.
interface tdm_clkgen_if #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 32
);
  import i2s_pkg::*;

  localparam int SLOT_IW = idx_w(NUM_SLOTS);
  localparam int BIT_IW  = idx_w(SLOT_W);

  logic               en;
  i2s_fmt_t           fmt;
  logic               sclk;
  logic               lrclk;
  logic               bclk_rise;
  logic               bclk_fall;
  logic               frame_start;
  logic [SLOT_IW-1:0] slot;
  logic [BIT_IW-1:0]  bit_idx;

`ifdef TDM_CLKGEN_FRAME_CTR_EN
  logic [31:0]        frame_cnt;

  modport master (
    input  en, fmt,
    output sclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx,
           frame_cnt
  );

  modport slave (
    output en, fmt,
    input  sclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx,
           frame_cnt
  );
`else
  modport master (
    input  en, fmt,
    output sclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx
  );

  modport slave (
    output en, fmt,
    input  sclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx
  );
`endif

endinterface

// File: rtl/tdm_clkgen_clk_div.sv
// clk_div_strobe: divides clk by 2*HALF_DIV into a 50% duty bit clock and
// emits single-cycle rise/fall strobes registered alongside the sclk edge.
// Ports:
//   clk, rst      - master clock, synchronous active-high reset
//   i_en          - run enable; low clears the divider like rst
//   o_sclk        - bit clock
//   o_rise/o_fall - strobes coincident with the sclk 0->1 / 1->0 change
//   o_fall_nxt    - combinational: the next edge registers a falling edge,
//                   lets the parent update its registers in the same cycle
module clk_div_strobe #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall,
  output logic o_fall_nxt
);

  localparam int CTR_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CTR_W-1:0] r_div_ctr;
  logic             r_sclk;
  logic             r_rise;
  logic             r_fall;
  logic             w_wrap;

  // With HALF_DIV=1 the counter is stuck at 0 and every cycle wraps.
  assign w_wrap = (r_div_ctr == CTR_W'(HALF_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_div_ctr <= '0;
      r_sclk    <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_wrap) begin
        r_div_ctr <= '0;
        r_sclk    <= ~r_sclk;
        r_rise    <= ~r_sclk;
        r_fall    <= r_sclk;
      end else begin
        r_div_ctr <= r_div_ctr + 1'b1;
      end
    end
  end

  assign o_sclk     = r_sclk;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_fall_nxt = i_en & w_wrap & r_sclk;

endmodule

// File: rtl/tdm_clkgen.sv
// tdm_clkgen: I2S/TDM master clock generator. Derives sclk and lrclk from
// clk, and provides clk-domain strobes plus slot/bit indices so data paths
// stay synchronous to clk. FS_RATIO clk cycles per frame, exactly.
// Ports:
//   clk, rst - master clock (MCLK), synchronous active-high reset
//   bus      - tdm_clkgen_if.master: en, fmt in; sclk, lrclk, bclk_rise,
//              bclk_fall, frame_start, slot, bit_idx (+frame_cnt) out
// Optional: define TDM_CLKGEN_FRAME_CTR_EN to add the 32-bit frame_cnt.
module tdm_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W    = 32,
  parameter int NUM_SLOTS = 2,
  parameter int FS_RATIO  = 256
) (
  input logic         clk,
  input logic         rst,
  tdm_clkgen_if.master bus
);

  localparam int FRAME_BITS = frame_bits(NUM_SLOTS, SLOT_W);
  localparam int HALF_DIV   = FS_RATIO / (2 * FRAME_BITS);
  localparam int FB_W       = $clog2(FRAME_BITS);
  localparam int SLOT_IW    = idx_w(NUM_SLOTS);
  localparam int BIT_IW     = idx_w(SLOT_W);

  localparam logic [FB_W-1:0]    FB_LAST   = FB_W'(FRAME_BITS - 1);
  localparam logic [FB_W-1:0]    FB_HALF   = FB_W'(FRAME_BITS / 2);
  localparam logic [BIT_IW-1:0]  BIT_LAST  = BIT_IW'(SLOT_W - 1);
  localparam logic [SLOT_IW-1:0] SLOT_LAST = SLOT_IW'(NUM_SLOTS - 1);

  if (SLOT_W < 8) begin : g_bad_slot_w
    $error("tdm_clkgen: SLOT_W must be at least 8");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
    $error("tdm_clkgen: NUM_SLOTS must be a power of 2 in 1..16");
  end
  if (FS_RATIO <= 0 || (FS_RATIO % (2 * FRAME_BITS)) != 0) begin : g_bad_ratio
    $error("tdm_clkgen: FS_RATIO must be a multiple of 2*NUM_SLOTS*SLOT_W");
  end

  logic w_sclk, w_rise, w_fall, w_fall_nxt;

  clk_div_strobe #(.HALF_DIV(HALF_DIV)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_en       (bus.en),
    .o_sclk     (w_sclk),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_fall_nxt (w_fall_nxt)
  );

  logic [FB_W-1:0]    r_fb;
  logic               r_lrclk;
  logic               r_frame_start;
  logic [SLOT_IW-1:0] r_slot;
  logic [BIT_IW-1:0]  r_bit_idx;
  i2s_fmt_t           r_fmt;

  logic               w_fb_wrap;
  logic [FB_W-1:0]    w_fb_nxt;
  logic [FB_W-1:0]    w_fb_nxt_p1;
  i2s_fmt_t           w_fmt_eff;
  logic               w_lrclk_nxt;

  assign w_fb_wrap   = (r_fb == FB_LAST);
  assign w_fb_nxt    = w_fb_wrap ? '0 : r_fb + 1'b1;
  assign w_fb_nxt_p1 = (w_fb_nxt == FB_LAST) ? '0 : w_fb_nxt + 1'b1;
  // The format register reloads at the frame boundary; bit 0 of the new
  // frame must already be encoded with the incoming format.
  assign w_fmt_eff   = w_fb_wrap ? bus.fmt : r_fmt;

  always_comb begin
    w_lrclk_nxt = 1'b0;
    case (w_fmt_eff)
      FMT_I2S:   w_lrclk_nxt = (w_fb_nxt_p1 >= FB_HALF);
      FMT_LJ:    w_lrclk_nxt = (w_fb_nxt < FB_HALF);
      FMT_DSP_A: w_lrclk_nxt = (w_fb_nxt == FB_LAST);
      FMT_DSP_B: w_lrclk_nxt = (w_fb_nxt == '0);
      default:   w_lrclk_nxt = 1'b0;
    endcase
  end

`ifdef TDM_CLKGEN_FRAME_CTR_EN
  logic [31:0] r_frame_cnt;
`endif

  // slot/bit_idx track fb incrementally; they wrap together with fb.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      r_fb          <= FB_LAST;
      r_lrclk       <= 1'b0;
      r_frame_start <= 1'b0;
      r_slot        <= SLOT_LAST;
      r_bit_idx     <= '0;
      r_fmt         <= bus.fmt;
`ifdef TDM_CLKGEN_FRAME_CTR_EN
      r_frame_cnt   <= '0;
`endif
    end else begin
      r_frame_start <= 1'b0;
      if (w_fall_nxt) begin
        r_fb    <= w_fb_nxt;
        r_lrclk <= w_lrclk_nxt;
        if (w_fb_wrap) begin
          r_frame_start <= 1'b1;
          r_slot        <= '0;
          r_bit_idx     <= BIT_LAST;
          r_fmt         <= bus.fmt;
`ifdef TDM_CLKGEN_FRAME_CTR_EN
          r_frame_cnt   <= r_frame_cnt + 32'd1;
`endif
        end else if (r_bit_idx == '0) begin
          r_slot    <= r_slot + 1'b1;
          r_bit_idx <= BIT_LAST;
        end else begin
          r_bit_idx <= r_bit_idx - 1'b1;
        end
      end
    end
  end

  assign bus.sclk        = w_sclk;
  assign bus.bclk_rise   = w_rise;
  assign bus.bclk_fall   = w_fall;
  assign bus.lrclk       = r_lrclk;
  assign bus.frame_start = r_frame_start;
  assign bus.slot        = r_slot;
  assign bus.bit_idx     = r_bit_idx;
`ifdef TDM_CLKGEN_FRAME_CTR_EN
  assign bus.frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_tdm_clkgen.sv
module tb_tdm_clkgen;
  import i2s_pkg::*;

  localparam int HD_A = 2, NS_A = 2, SW_A = 32, L_A = 64;
  localparam int HD_B = 1, NS_B = 8, SW_B = 32, L_B = 256;

  typedef struct packed {
    logic       sclk;
    logic       lrclk;
    logic       rise;
    logic       fall;
    logic       fs;
    logic [7:0] slot;
    logic [7:0] bitx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_clkgen_if #(.NUM_SLOTS(NS_A), .SLOT_W(SW_A)) bus_a ();
  tdm_clkgen_if #(.NUM_SLOTS(NS_B), .SLOT_W(SW_B)) bus_b ();

  tdm_clkgen #(.SLOT_W(SW_A), .NUM_SLOTS(NS_A), .FS_RATIO(256)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  tdm_clkgen #(.SLOT_W(SW_B), .NUM_SLOTS(NS_B), .FS_RATIO(512)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference: everything follows from t, the number of enabled clk edges
  // since release. sclk toggles every hd edges; the n-th falling edge
  // carries frame bit (n-1) mod L.
  function automatic obs_t model(input int t, input int hd, input int ns,
                                 input int sw, input logic [1:0] f);
    obs_t o;
    int L, tog, n, fb;
    L = ns * sw;
    o = '0;
    o.slot = 8'(ns - 1);
    if (t == 0) return o;
    tog = t / hd;
    o.sclk = (tog % 2) == 1;
    o.rise = (t % hd == 0) && (tog % 2 == 1);
    o.fall = (t % hd == 0) && (tog % 2 == 0);
    n = t / (2 * hd);
    if (n == 0) return o;
    fb = (n - 1) % L;
    o.slot = 8'(fb / sw);
    o.bitx = 8'(sw - 1 - fb % sw);
    o.fs = o.fall && (fb == 0);
    case (f)
      2'd0:    o.lrclk = ((fb + 1) % L) >= L / 2;
      2'd1:    o.lrclk = fb < L / 2;
      2'd2:    o.lrclk = fb == L - 1;
      default: o.lrclk = fb == 0;
    endcase
    return o;
  endfunction

  function automatic bit frame_edge(input int t, input int hd, input int L);
    return (t > 0) && (t % (2 * hd) == 0) && (((t / (2 * hd)) - 1) % L == 0);
  endfunction

  function automatic int frames_model(input int t, input int hd, input int L);
    int n;
    n = t / (2 * hd);
    return (n == 0) ? 0 : (n - 1) / L + 1;
  endfunction

  function automatic obs_t get_a();
    return {bus_a.sclk, bus_a.lrclk, bus_a.bclk_rise, bus_a.bclk_fall,
            bus_a.frame_start, 8'(bus_a.slot), 8'(bus_a.bit_idx)};
  endfunction

  function automatic obs_t get_b();
    return {bus_b.sclk, bus_b.lrclk, bus_b.bclk_rise, bus_b.bclk_fall,
            bus_b.frame_start, 8'(bus_b.slot), 8'(bus_b.bit_idx)};
  endfunction

  int         t_a = 0, t_b = 0;
  logic [1:0] f_a = 2'd0, f_b = 2'd0;
  obs_t       exp_a = '0, exp_b = '0;

  always @(posedge clk) begin
    if (rst || !bus_a.en) begin
      t_a = 0;
      f_a = bus_a.fmt;
    end else begin
      t_a++;
      if (frame_edge(t_a, HD_A, L_A)) f_a = bus_a.fmt;
    end
    exp_a = model(t_a, HD_A, NS_A, SW_A, f_a);
    if (rst || !bus_b.en) begin
      t_b = 0;
      f_b = bus_b.fmt;
    end else begin
      t_b++;
      if (frame_edge(t_b, HD_B, L_B)) f_b = bus_b.fmt;
    end
    exp_b = model(t_b, HD_B, NS_B, SW_B, f_b);
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (get_a() !== obs_t'({5'b0, 8'd1, 8'd0})) begin
      n_err++;
      $display("FAIL reset_a got=%h exp=%h", get_a(), obs_t'({5'b0, 8'd1, 8'd0}));
    end
    n_cmp++;
    if (get_b() !== obs_t'({5'b0, 8'd7, 8'd0})) begin
      n_err++;
      $display("FAIL reset_b got=%h exp=%h", get_b(), obs_t'({5'b0, 8'd7, 8'd0}));
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_i2s();
    int first_fs = -1, prev_fs = -1, prev_rise = -1, lr_falls = 0;
    logic prev_lr = 1'b0;
    bus_a.fmt = FMT_I2S;
    bus_a.en  = 1'b1;
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL i2s_stream k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
      if (bus_a.bclk_rise) begin
        if (prev_rise >= 0) begin
          n_cmp++;
          if (k - prev_rise != 4) begin
            n_err++;
            $display("FAIL i2s_sclk_period got=%0d exp=4", k - prev_rise);
          end
        end
        prev_rise = k;
      end
      if (bus_a.frame_start) begin
        if (first_fs < 0) first_fs = k;
        else begin
          n_cmp++;
          if (k - prev_fs != 256) begin
            n_err++;
            $display("FAIL i2s_frame_period got=%0d exp=256", k - prev_fs);
          end
        end
        prev_fs = k;
      end
      if (prev_lr && !bus_a.lrclk) begin
        lr_falls++;
        n_cmp++;
        if (!(bus_a.bclk_fall && bus_a.slot == 1'b1 && bus_a.bit_idx == 5'd0)) begin
          n_err++;
          $display("FAIL i2s_lr_fall_pos slot=%0d bit=%0d fall=%0d exp slot=1 bit=0 fall=1",
                   bus_a.slot, bus_a.bit_idx, bus_a.bclk_fall);
        end
      end
      prev_lr = bus_a.lrclk;
    end
    n_cmp++;
    if (first_fs != 4) begin
      n_err++;
      $display("FAIL i2s_first_fs got=%0d exp=4", first_fs);
    end
    n_cmp++;
    if (lr_falls != 3) begin
      n_err++;
      $display("FAIL i2s_lr_fall_count got=%0d exp=3", lr_falls);
    end
  endtask

  task automatic test_lj();
    int rises = 0;
    logic prev_lr = 1'b0;
    bus_a.fmt = FMT_LJ;
    do_reset();
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL lj_stream k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
      if (!prev_lr && bus_a.lrclk) begin
        rises++;
        n_cmp++;
        if (bus_a.frame_start !== 1'b1) begin
          n_err++;
          $display("FAIL lj_rise_align frame_start=%0d exp=1", bus_a.frame_start);
        end
      end
      if (prev_lr && !bus_a.lrclk) begin
        n_cmp++;
        if (!(bus_a.slot == 1'b1 && bus_a.bit_idx == 5'd31)) begin
          n_err++;
          $display("FAIL lj_fall_pos slot=%0d bit=%0d exp slot=1 bit=31",
                   bus_a.slot, bus_a.bit_idx);
        end
      end
      prev_lr = bus_a.lrclk;
    end
    n_cmp++;
    if (rises != 3) begin
      n_err++;
      $display("FAIL lj_rise_count got=%0d exp=3", rises);
    end
  endtask

  task automatic test_tdm8();
    int hi = 0, run = 0, runs_seen = 0;
    logic prev_lr = 1'b0, prev_sclk = 1'b0;
    logic [2:0] prev_slot = 3'd7;
    bus_a.en  = 1'b0;
    bus_b.fmt = FMT_DSP_B;
    bus_b.en  = 1'b1;
    do_reset();
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_b() !== exp_b) begin
        n_err++;
        $display("FAIL tdm8_stream k=%0d got=%h exp=%h", k, get_b(), exp_b);
      end
      n_cmp++;
      if (bus_b.sclk === prev_sclk) begin
        n_err++;
        $display("FAIL tdm8_sclk_div2 k=%0d got=%0d exp=%0d", k, bus_b.sclk, ~prev_sclk);
      end
      prev_sclk = bus_b.sclk;
      if (bus_b.lrclk) hi++;
      if (!prev_lr && bus_b.lrclk) begin
        n_cmp++;
        if (bus_b.frame_start !== 1'b1) begin
          n_err++;
          $display("FAIL tdm8_lr_align frame_start=%0d exp=1", bus_b.frame_start);
        end
      end
      prev_lr = bus_b.lrclk;
      if (bus_b.slot != prev_slot) begin
        if (runs_seen > 0) begin
          n_cmp++;
          if (run != 64) begin
            n_err++;
            $display("FAIL tdm8_slot_len slot=%0d got=%0d exp=64", prev_slot, run);
          end
        end
        runs_seen++;
        run = 0;
        prev_slot = bus_b.slot;
      end
      run++;
    end
    n_cmp++;
    if (hi != 6) begin
      n_err++;
      $display("FAIL tdm8_lr_high_cycles got=%0d exp=6", hi);
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_fmt_switch();
    bit found = 0, fs_seen = 0, i2s_ok = 0;
    int pulse = 0;
    bus_a.fmt = FMT_DSP_A;
    bus_a.en  = 1'b1;
    do_reset();
    for (int k = 1; k <= 400 && !found; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL sw_pre k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
      if (bus_a.slot == 1'b0 && bus_a.bit_idx == 5'd21) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL sw_wait_fb10 got=timeout exp=fb10");
    end
    bus_a.fmt = FMT_I2S;
    for (int k = 1; k <= 600 && !i2s_ok; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL sw_stream k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
      if (bus_a.frame_start) fs_seen = 1;
      else if (!fs_seen && bus_a.lrclk) pulse++;
      if (fs_seen && bus_a.slot == 1'b1 && bus_a.bit_idx == 5'd31) begin
        i2s_ok = 1;
        n_cmp++;
        if (bus_a.lrclk !== 1'b1) begin
          n_err++;
          $display("FAIL sw_i2s_active lrclk=%0d exp=1", bus_a.lrclk);
        end
      end
    end
    n_cmp++;
    if (pulse != 4) begin
      n_err++;
      $display("FAIL sw_dspa_pulse got=%0d exp=4", pulse);
    end
    n_cmp++;
    if (!i2s_ok) begin
      n_err++;
      $display("FAIL sw_next_frame got=timeout exp=reached");
    end
  endtask

  task automatic test_en_drop();
    bit found = 0;
    int got_fs = -1;
    bus_a.fmt = FMT_LJ;
    bus_a.en  = 1'b1;
    do_reset();
    for (int k = 1; k <= 400 && !found; k++) begin
      @(negedge clk);
      if (bus_a.slot == 1'b0 && bus_a.bit_idx == 5'd11) found = 1;
    end
    n_cmp++;
    if (!found || bus_a.lrclk !== 1'b1) begin
      n_err++;
      $display("FAIL en_wait_fb20 found=%0d lrclk=%0d exp found=1 lrclk=1", found, bus_a.lrclk);
    end
    bus_a.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (get_a() !== obs_t'({5'b0, 8'd1, 8'd0})) begin
          n_err++;
          $display("FAIL en_immediate got=%h exp=%h", get_a(), obs_t'({5'b0, 8'd1, 8'd0}));
        end
      end
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL en_hold k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
    end
    bus_a.en = 1'b1;
    for (int k = 1; k <= 20 && got_fs < 0; k++) begin
      @(negedge clk);
      if (bus_a.frame_start) got_fs = k;
    end
    n_cmp++;
    if (got_fs != 2 * HD_A) begin
      n_err++;
      $display("FAIL en_restart_fs got=%0d exp=%0d", got_fs, 2 * HD_A);
    end
  endtask

`ifdef TDM_CLKGEN_FRAME_CTR_EN
  task automatic test_frame_cnt();
    bus_a.fmt = FMT_I2S;
    bus_a.en  = 1'b1;
    do_reset();
    repeat (1280) @(negedge clk);
    n_cmp++;
    if (bus_a.frame_cnt !== 32'd5) begin
      n_err++;
      $display("FAIL fcnt_five got=%0d exp=5", bus_a.frame_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.frame_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL fcnt_rst got=%0d exp=0", bus_a.frame_cnt);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (bus_a.frame_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL fcnt_restart got=%0d exp=1", bus_a.frame_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int r;
    bus_a.en = 1'b1;
    do_reset();
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_a() !== exp_a) begin
        n_err++;
        $display("FAIL rand_a k=%0d got=%h exp=%h", k, get_a(), exp_a);
      end
`ifdef TDM_CLKGEN_FRAME_CTR_EN
      n_cmp++;
      if (bus_a.frame_cnt !== 32'(frames_model(t_a, HD_A, L_A))) begin
        n_err++;
        $display("FAIL rand_a_fcnt k=%0d got=%0d exp=%0d", k, bus_a.frame_cnt,
                 frames_model(t_a, HD_A, L_A));
      end
`endif
      r = int'($urandom_range(0, 999));
      rst = (r == 7);
      if (r < 6) bus_a.fmt = i2s_fmt_t'($urandom_range(0, 3));
      else if (r < 8 && bus_a.en) bus_a.en = 1'b0;
      else if (!bus_a.en && r < 200) bus_a.en = 1'b1;
    end
    rst = 1'b0;
    bus_a.en = 1'b0;
    bus_b.en = 1'b1;
    do_reset();
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_b() !== exp_b) begin
        n_err++;
        $display("FAIL rand_b k=%0d got=%h exp=%h", k, get_b(), exp_b);
      end
      r = int'($urandom_range(0, 999));
      rst = (r == 7);
      if (r < 10) bus_b.fmt = i2s_fmt_t'($urandom_range(0, 3));
      else if (r < 12 && bus_b.en) bus_b.en = 1'b0;
      else if (!bus_b.en && r < 200) bus_b.en = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus_a.en  = 1'b0;
    bus_a.fmt = FMT_I2S;
    bus_b.en  = 1'b0;
    bus_b.fmt = FMT_I2S;
    @(negedge clk);
    test_reset();
    test_i2s();
    test_lj();
    test_tdm8();
    test_fmt_switch();
    test_en_drop();
`ifdef TDM_CLKGEN_FRAME_CTR_EN
    test_frame_cnt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
